// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the fetch/data SRAM port arbiter: requester ids, tag entries
// and the legal SRAM latency range.
package sram_arb_pkg;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    vld;
    req_id_e id;
    logic    is_wr;
  } tag_t;

  localparam int unsigned SramLatMin = 1;
  localparam int unsigned SramLatMax = 4;

  function automatic logic sram_lat_legal(input int unsigned lat);
    return (lat >= SramLatMin) && (lat <= SramLatMax);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Request/response channels of both requesters plus the single SRAM port.
// master: the core requesters and the RAM itself; slave: the arbiter.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_W-1:0]     if_req_addr;
  logic                  if_rsp_valid;
  logic [DATA_W-1:0]     if_rsp_rdata;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic [ADDR_W-1:0]     d_req_addr;
  logic [DATA_W/8-1:0]   d_req_wstrb;
  logic [DATA_W-1:0]     d_req_wdata;
  logic                  d_rsp_valid;
  logic [DATA_W-1:0]     d_rsp_rdata;

  logic                  sram_en;
  logic [DATA_W/8-1:0]   sram_we;
  logic [ADDR_W-1:0]     sram_addr;
  logic [DATA_W-1:0]     sram_wdata;
  logic [DATA_W-1:0]     sram_rdata;

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_rdata,
    output d_req_valid, d_req_addr, d_req_wstrb, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_rdata,
    input  d_req_valid, d_req_addr, d_req_wstrb, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

endinterface

// File: rtl/sram_port_arbiter_tag_pipe.sv
// Depth-stage shift register of request tags; the last stage lines up with the
// cycle the SRAM returns data for that request. Synchronous clear drops all tags.
module sram_arb_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [Depth-1:0] stage_q, stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_i;
    for (int i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (reset) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port SRAM, one accept per
// cycle, with in-order responses SRAM_LAT cycles later. ARB_RR_EN selects
// round-robin arbitration; otherwise data has fixed priority over fetch.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SRAM_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  sram_port_arbiter_if.slave bus
);

  if (!sram_lat_legal(SRAM_LAT) || (DATA_W % 8 != 0)) begin : g_bad_param
    $error("sram_port_arbiter: illegal SRAM_LAT or DATA_W");
  end

  logic    gnt_vld;
  req_id_e gnt_id;
  tag_t    tag_in;
  tag_t    tag_out;
  logic    rsp_fire;

`ifdef ARB_RR_EN
  req_id_e last_grant_q, last_grant_d;
`endif

  // Grant is purely combinational; nothing is granted while reset is high.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = REQ_IF;
    if (!reset) begin
      if (bus.if_req_valid && bus.d_req_valid) begin
        gnt_vld = 1'b1;
`ifdef ARB_RR_EN
        gnt_id  = (last_grant_q == REQ_IF) ? REQ_D : REQ_IF;
`else
        gnt_id  = REQ_D;
`endif
      end else if (bus.d_req_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = REQ_D;
      end else if (bus.if_req_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = REQ_IF;
      end
    end
  end

`ifdef ARB_RR_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (reset) begin
      last_grant_d = REQ_IF;
    end else if (gnt_vld) begin
      last_grant_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    last_grant_q <= last_grant_d;
  end
`endif

  // Granted requester drives the SRAM port in the accept cycle.
  always_comb begin
    bus.if_req_ready = 1'b0;
    bus.d_req_ready  = 1'b0;
    bus.sram_en      = 1'b0;
    bus.sram_we      = '0;
    bus.sram_addr    = '0;
    bus.sram_wdata   = '0;
    tag_in           = '0;
    if (gnt_vld) begin
      bus.sram_en  = 1'b1;
      tag_in.vld   = 1'b1;
      tag_in.id    = gnt_id;
      if (gnt_id == REQ_D) begin
        bus.d_req_ready = 1'b1;
        bus.sram_we     = bus.d_req_wstrb;
        bus.sram_addr   = bus.d_req_addr;
        bus.sram_wdata  = bus.d_req_wdata;
        tag_in.is_wr    = |bus.d_req_wstrb;
      end else begin
        bus.if_req_ready = 1'b1;
        bus.sram_addr    = bus.if_req_addr;
      end
    end
  end

  sram_arb_tag_pipe #(
    .Depth (SRAM_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Gate by reset so stale tags never pulse during the clearing cycle.
  assign rsp_fire = tag_out.vld && !reset;

  always_comb begin
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_rdata = '0;
    bus.d_rsp_valid  = 1'b0;
    bus.d_rsp_rdata  = '0;
    if (rsp_fire) begin
      if (tag_out.id == REQ_D) begin
        bus.d_rsp_valid = 1'b1;
        bus.d_rsp_rdata = tag_out.is_wr ? '0 : bus.sram_rdata;
      end else begin
        bus.if_rsp_valid = 1'b1;
        bus.if_rsp_rdata = bus.sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a latency-1 instance backed by a small
// byte-writable RAM model and a latency-3 instance backed by an address-hash RAM.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1)
  );

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SRAM_LAT(3)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (b3)
  );

  // Latency-1 RAM: read-first, byte writes land at the access edge.
  logic [31:0] mem1 [256];
  logic [31:0] rd1_q;
  always @(posedge clk) begin
    if (b1.sram_en) begin
      rd1_q <= mem1[b1.sram_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (b1.sram_we[b]) mem1[b1.sram_addr[9:2]][8*b +: 8] <= b1.sram_wdata[8*b +: 8];
      end
    end
  end
  assign b1.sram_rdata = rd1_q;

  logic [31:0] rd3_q [3];
  always @(posedge clk) begin
    rd3_q[0] <= b3.sram_en ? (32'hC0DE_0000 ^ b3.sram_addr) : 32'h0;
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign b3.sram_rdata = rd3_q[2];

  function automatic logic [31:0] word(input int idx);
    return (idx == 0) ? 32'h02bf_fc0c : (32'hA000_0000 | idx);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int lat, input logic iv, input logic dv,
                     input logic [31:0] ir, input logic [31:0] dr);
    exp_t e;
    logic has;
    if (iv || dv) begin
      has = (lat == 1) ? (q1.size() != 0) : (q3.size() != 0);
      checks++;
      assert (has) else begin
        errors++;
        $error("FAIL rsp_unexpected lat%0d got if_v=%0b d_v=%0b expected no pulse", lat, iv, dv);
      end
      if (has) begin
        if (lat == 1) e = q1.pop_front();
        else e = q3.pop_front();
        checks++;
        assert ({iv, dv, ir, dr, cyc} ===
                {!e.id, e.id, (e.id ? 32'h0 : e.data), (e.id ? e.data : 32'h0), e.due}) else begin
          errors++;
          $error("FAIL rsp_lat%0d got if_v=%0b d_v=%0b if_d=%h d_d=%h cyc=%0d expected id=%0b data=%h cyc=%0d",
                 lat, iv, dv, ir, dr, cyc, e.id, e.data, e.due);
        end
      end
    end else begin
      checks++;
      assert ({ir, dr} === 64'h0) else begin
        errors++;
        $error("FAIL rdata_idle_lat%0d got if_d=%h d_d=%h expected 0", lat, ir, dr);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(1, b1.if_rsp_valid, b1.d_rsp_valid, b1.if_rsp_rdata, b1.d_rsp_rdata);
    mon(3, b3.if_rsp_valid, b3.d_rsp_valid, b3.if_rsp_rdata, b3.d_rsp_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic id, input logic [31:0] d);
    q1.push_back('{id: id, data: d, due: cyc + 1});
  endtask

  task automatic push3(input logic id, input logic [31:0] d);
    q3.push_back('{id: id, data: d, due: cyc + 3});
  endtask

  task automatic idle_all();
    b1.if_req_valid = 1'b0; b1.d_req_valid = 1'b0; b1.d_req_wstrb = '0; b1.d_req_wdata = '0;
    b3.if_req_valid = 1'b0; b3.d_req_valid = 1'b0; b3.d_req_wstrb = '0; b3.d_req_wdata = '0;
  endtask

  task automatic chk_reset_outputs(input string tag, input int lat);
    if (lat == 1) begin
      chk({tag, "_ctl"}, {b1.if_req_ready, b1.d_req_ready, b1.sram_en, b1.sram_we,
                          b1.if_rsp_valid, b1.d_rsp_valid}, '0);
      chk({tag, "_bus"}, {b1.sram_addr, b1.sram_wdata, b1.if_rsp_rdata, b1.d_rsp_rdata}, '0);
    end else begin
      chk({tag, "_ctl"}, {b3.if_req_ready, b3.d_req_ready, b3.sram_en, b3.sram_we,
                          b3.if_rsp_valid, b3.d_rsp_valid}, '0);
      chk({tag, "_bus"}, {b3.sram_addr, b3.sram_wdata, b3.if_rsp_rdata, b3.d_rsp_rdata}, '0);
    end
  endtask

  initial begin
    int ia, da;
    for (int i = 0; i < 256; i++) mem1[i] = word(i);
    rst1 = 1'b1;
    rst3 = 1'b1;
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h44; b1.d_req_valid = 1'b1;
    b1.d_req_addr = 32'h48; b1.d_req_wstrb = 4'hF; b1.d_req_wdata = 32'h5555_aaaa;
    b3.if_req_valid = 1'b1; b3.if_req_addr = 32'h44; b3.d_req_valid = 1'b1;
    b3.d_req_addr = 32'h48; b3.d_req_wstrb = 4'h0; b3.d_req_wdata = 32'h0;
    step();
    step();
    @(negedge clk);
    chk_reset_outputs("reset1", 1);
    chk_reset_outputs("reset3", 3);
    step();
    idle_all();
    rst1 = 1'b0;
    rst3 = 1'b0;
    step();

    // Fetch only on the latency-1 port.
    b1.if_req_valid = 1'b1;
    b1.if_req_addr  = 32'h1c00_0000;
    @(negedge clk);
    chk("fetch_ctl", {b1.if_req_ready, b1.d_req_ready, b1.sram_en, b1.sram_we}, {3'b101, 4'h0});
    chk("fetch_addr", b1.sram_addr, 32'h1c00_0000);
    push1(REQ_IF, 32'h02bf_fc0c);
    step();
    b1.if_req_valid = 1'b0;
    @(negedge clk);
    chk("idle_bus", {b1.if_req_ready, b1.d_req_ready, b1.sram_en, b1.sram_we,
                     b1.sram_addr, b1.sram_wdata}, '0);
    step();

`ifdef ARB_RR_EN
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    ia = 0;
    da = 0;
    for (int k = 0; k < 4; k++) begin
      b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h40 + 32'(4 * ia);
      b1.d_req_valid  = 1'b1; b1.d_req_addr  = 32'h80 + 32'(4 * da);
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("rr_grant_d", {b1.if_req_ready, b1.d_req_ready, b1.sram_addr}, {2'b01, 32'h80 + 32'(4 * da)});
        push1(REQ_D, word(32 + da));
        da++;
      end else begin
        chk("rr_grant_if", {b1.if_req_ready, b1.d_req_ready, b1.sram_addr}, {2'b10, 32'h40 + 32'(4 * ia)});
        push1(REQ_IF, word(16 + ia));
        ia++;
      end
      step();
    end
    idle_all();
    step();
`else
    ia = 0;
    da = 0;
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h1c00_0004;
    b1.d_req_valid  = 1'b1; b1.d_req_addr  = 32'h100;
    @(negedge clk);
    chk("prio_d_wins", {b1.if_req_ready, b1.d_req_ready, b1.sram_addr}, {2'b01, 32'h100});
    push1(REQ_D, word(64));
    step();
    b1.d_req_valid = 1'b0;
    @(negedge clk);
    chk("prio_if_next", {b1.if_req_ready, b1.d_req_ready, b1.sram_addr}, {2'b10, 32'h1c00_0004});
    push1(REQ_IF, word(1));
    step();
    idle_all();
    step();
`endif

    // Full write, then same-address read the next cycle.
    b1.d_req_valid = 1'b1; b1.d_req_addr = 32'h20;
    b1.d_req_wstrb = 4'hF; b1.d_req_wdata = 32'hdead_beef;
    @(negedge clk);
    chk("write_port", {b1.d_req_ready, b1.sram_en, b1.sram_we, b1.sram_wdata}, {2'b11, 4'hF, 32'hdead_beef});
    push1(REQ_D, 32'h0);
    step();
    b1.d_req_wstrb = 4'h0; b1.d_req_wdata = 32'h0;
    @(negedge clk);
    chk("read_after_write_port", {b1.d_req_ready, b1.sram_we, b1.sram_addr}, {1'b1, 4'h0, 32'h20});
    push1(REQ_D, 32'hdead_beef);
    step();
    // Partial strobe write merges with the old word.
    b1.d_req_addr = 32'h24; b1.d_req_wstrb = 4'b0011; b1.d_req_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("partial_we", b1.sram_we, 4'b0011);
    push1(REQ_D, 32'h0);
    step();
    b1.d_req_wstrb = 4'h0; b1.d_req_wdata = 32'h0;
    @(negedge clk);
    push1(REQ_D, (word(9) & 32'hFFFF_0000) | 32'h0000_5678);
    step();
    idle_all();
    step(); step(); step();
    @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    step();

    // Latency-3 port: I, D, I in consecutive cycles.
    b3.if_req_valid = 1'b1; b3.if_req_addr = 32'h10;
    @(negedge clk);
    chk("lat3_acc0", {b3.if_req_ready, b3.d_req_ready}, 2'b10);
    push3(REQ_IF, 32'hC0DE_0010);
    step();
    b3.if_req_valid = 1'b0;
    b3.d_req_valid = 1'b1; b3.d_req_addr = 32'h14;
    @(negedge clk);
    chk("lat3_acc1", {b3.if_req_ready, b3.d_req_ready}, 2'b01);
    push3(REQ_D, 32'hC0DE_0014);
    step();
    b3.d_req_valid = 1'b0;
    b3.if_req_valid = 1'b1; b3.if_req_addr = 32'h18;
    @(negedge clk);
    chk("lat3_acc2", {b3.if_req_ready, b3.d_req_ready}, 2'b10);
    push3(REQ_IF, 32'hC0DE_0018);
    step();
    idle_all();
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    chk("q3_drained", q3.size(), 0);
    step();

    // Two reads in flight, then reset: both must be dropped.
    b3.if_req_valid = 1'b1; b3.if_req_addr = 32'h30;
    @(negedge clk);
    chk("flush_acc0", b3.if_req_ready, 1'b1);
    step();
    b3.if_req_valid = 1'b0;
    b3.d_req_valid = 1'b1; b3.d_req_addr = 32'h34;
    @(negedge clk);
    chk("flush_acc1", b3.d_req_ready, 1'b1);
    step();
    rst3 = 1'b1;
    b3.if_req_valid = 1'b1;
    @(negedge clk);
    chk_reset_outputs("flush_rst_a", 3);
    step();
    @(negedge clk);
    chk_reset_outputs("flush_rst_b", 3);
    step();
    rst3 = 1'b0;
    idle_all();
    for (int i = 0; i < 6; i++) step();
    @(negedge clk);
    chk("q3_flush_empty", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
